// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory port that turns controller load/store strobes into word-aligned bus requests
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_stall,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] f3_q;
  logic [1:0] lo_q;
  logic strobe, legal, aligned, ld_ok, st_ok, timeout, start, finish;
  logic [3:0] be;
  logic [31:0] wd, sh, ext;
  always_comb begin
    strobe = mem_read | mem_write;
    ld_ok = funct3 != 3'b011 && funct3[2:1] != 2'b11;
    st_ok = !funct3[2] && funct3[1:0] != 2'b11;
    aligned = !(funct3[0] && addr[0]) && !(funct3[1] && addr[1:0] != 2'b00);
    legal = (mem_write ? st_ok : ld_ok) && aligned;
    be = !mem_write ? 4'b1111 : funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
         funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
    start = state == IDLE && strobe;
    finish = state == BUSY && (bus_ready || timeout);
    state_n = state == IDLE ? (strobe ? (legal ? BUSY : DONE) : IDLE) :
              state == BUSY ? (finish ? DONE : BUSY) : IDLE;
    mem_stall = start || state == BUSY;
    sh = bus_rdata >> {lo_q, 3'b000};
    ext = f3_q[1:0] == 2'b00 ? {{24{sh[7] & ~f3_q[2]}}, sh[7:0]} :
          f3_q[1:0] == 2'b01 ? {{16{sh[15] & ~f3_q[2]}}, sh[15:0]} : bus_rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      f3_q <= '0;
      lo_q <= '0;
      rdata <= '0;
      misaligned <= 1'b0;
      bus_err <= 1'b0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
    end else begin
      state <= state_n;
      cnt <= state == BUSY ? cnt + CW'(1) : '0;
      misaligned <= start && !legal;
      bus_err <= state == BUSY && !bus_ready && timeout;
      if (start && legal) begin
        bus_req <= 1'b1;
        bus_we <= mem_write;
        bus_addr <= {addr[31:2], 2'b00};
        bus_be <= be;
        bus_wdata <= wd;
        f3_q <= funct3;
        lo_q <= addr[1:0];
      end
      if (finish) bus_req <= 1'b0;
      if (state == BUSY && bus_ready && !bus_we) rdata <= ext;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench for mem_access_unit against a byte-lane reference model
module tb_mem_access_unit;
  localparam int T = 4;
  logic clk = 0, rst = 1;
  logic mem_read = 0, mem_write = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic mem_stall, misaligned, bus_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  logic bus_ready = 0;
  logic [31:0] bus_rdata = 0;
  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .mem_stall(mem_stall), .rdata(rdata), .misaligned(misaligned),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit ill, we, err;
    bit [3:0] be;
    bit [31:0] wd, ad, rd;
    int st;
  } exp_t;
  exp_t q[$];
  int n_tests = 0, n_fail = 0;
  int cur_waits = 0, wcnt = 0;
  bit [31:0] model_rdata = 0;
  bit mon_en = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask
  task automatic model(input bit wr, input bit [2:0] f, input bit [31:0] a, input bit [31:0] wdv,
                       input int w, input bit [31:0] br, output exp_t e);
    int n, k;
    bit [31:0] v;
    n = 1 << f[1:0];
    k = a % 4;
    e.we = wr;
    e.ill = wr ? (f > 2) : (f == 3 || f == 6 || f == 7);
    if (n <= 4 && (a % n) != 0) e.ill = 1;
    e.err = !e.ill && w >= T;
    e.st = e.ill ? 1 : 1 + (w >= T ? T : w + 1);
    e.ad = a - k;
    e.be = 4'b1111;
    e.wd = 0;
    if (wr && !e.ill) begin
      e.be = 0;
      for (int i = 0; i < n; i++) e.be[k + i] = 1;
      for (int j = 0; j < 4; j++) e.wd[8*j +: 8] = wdv[8*(j % n) +: 8];
    end
    if (!wr && !e.ill && !e.err) begin
      v = br >> (8 * k);
      if (n == 1) v = f[2] ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      else if (n == 2) v = f[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      model_rdata = v;
    end
    e.rd = model_rdata;
  endtask
  // bus responder: ready after cur_waits BUSY cycles, random noise while no request
  always @(negedge clk) begin
    if (bus_req) begin
      bus_ready <= (wcnt == cur_waits);
      wcnt <= wcnt + 1;
    end else begin
      bus_ready <= 1'($urandom_range(0, 1));
      wcnt <= 0;
    end
  end
  int stalls = 0;
  bit prev = 0, req_seen = 0, unstable = 0, early = 0;
  logic [31:0] c_addr, c_wd;
  logic [3:0] c_be;
  logic c_we;
  always @(negedge clk) begin
    if (!mon_en) begin
      prev = 0; stalls = 0; req_seen = 0; unstable = 0; early = 0;
    end else begin
      if (mem_stall) begin
        stalls++;
        if (misaligned || bus_err) early = 1;
        if (bus_req) begin
          if (!req_seen) begin
            c_addr = bus_addr; c_wd = bus_wdata; c_be = bus_be; c_we = bus_we;
          end else if (c_addr !== bus_addr || c_wd !== bus_wdata || c_be !== bus_be || c_we !== bus_we)
            unstable = 1;
          req_seen = 1;
        end
      end else if (prev) begin
        if (q.size() == 0) chk("queue_underflow", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("stall_cycles", stalls, e.st);
          chk("misaligned", misaligned, e.ill);
          chk("bus_err", bus_err, e.err);
          chk("rdata", rdata, e.rd);
          chk("req_low_done", bus_req, 0);
          chk("req_issued", req_seen, !e.ill);
          chk("early_pulse", early, 0);
          if (!e.ill) begin
            chk("bus_we", c_we, e.we);
            chk("bus_addr", c_addr, e.ad);
            chk("bus_be", c_be, e.be);
            if (e.we) chk("bus_wdata", c_wd, e.wd);
            chk("bus_stable", unstable, 0);
          end
        end
        stalls = 0; req_seen = 0; unstable = 0; early = 0;
      end
      prev = mem_stall;
    end
  end
  task automatic acc(input bit rd, input bit wr, input bit [2:0] f, input bit [31:0] a,
                     input bit [31:0] wdv, input int w, input bit [31:0] br);
    exp_t e;
    int k = 0;
    model(wr, f, a, wdv, w, br, e);
    q.push_back(e);
    cur_waits = w; bus_rdata = br;
    mem_read = rd; mem_write = wr; funct3 = f; addr = a; wdata = wdv;
    do begin
      @(posedge clk); #1;
      k++;
    end while (mem_stall && k < 60);
    if (k >= 60) chk("stall_timeout", 1, 0);
    mem_read = 0; mem_write = 0;
    if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", bus_req, 0); chk("rst_we", bus_we, 0); chk("rst_be", bus_be, 0);
    chk("rst_addr", bus_addr, 0); chk("rst_wdata", bus_wdata, 0); chk("rst_rdata", rdata, 0);
    chk("rst_mis", misaligned, 0); chk("rst_err", bus_err, 0); chk("rst_stall", mem_stall, 0);
    @(posedge clk); #1;
    rst = 0; mon_en = 1;
    acc(1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF_1234);
    acc(0, 1, 3'b001, 32'h22, 32'h0000_BEEF, 1, 0);
    acc(1, 0, 3'b010, 32'h41, 0, 0, 0);
    acc(1, 0, 3'b101, 32'h2, 0, 3, 32'h9ABC_0000);
    acc(1, 0, 3'b010, 32'h80, 0, 1000, 32'h1234_5678);
    acc(1, 1, 3'b000, 32'h7, 32'h55, 0, 0);
    for (int i = 0; i < 300; i++) begin
      int s, w;
      s = $urandom_range(0, 2);
      w = ($urandom_range(0, 9) == 0) ? T + $urandom_range(0, 2) : $urandom_range(0, T - 1);
      acc(s != 1, s != 0, 3'($urandom_range(0, 7)), $urandom, $urandom, w, $urandom);
    end
    @(posedge clk); #1;
    mon_en = 0;
    cur_waits = 1000; bus_rdata = 32'hDEAD_BEEF;
    mem_read = 1; funct3 = 3'b010; addr = 32'h200;
    repeat (3) begin @(posedge clk); #1; end
    chk("busy_req", bus_req, 1);
    rst = 1; mem_read = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("mid_rst_req", bus_req, 0); chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_err", bus_err, 0); chk("mid_rst_stall", mem_stall, 0);
    @(negedge clk);
    chk("mid_rst_err2", bus_err, 0); chk("mid_rst_mis", misaligned, 0);
    model_rdata = 0;
    @(posedge clk); #1;
    mon_en = 1;
    acc(1, 0, 3'b001, 32'h6, 0, 2, 32'h8001_7FFF);
    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
